// File: rtl/aes_disp_pkg.sv
// Shared phase codes, display constants and FSM state type for the AES
// phase sequencer and its display consumers.
package aes_disp_pkg;

    localparam logic [3:0] PH_IDLE       = 4'd0;
    localparam logic [3:0] PH_LOAD       = 4'd1;
    localparam logic [3:0] PH_ROUND_BASE = 4'd1;
    localparam logic [3:0] PH_DONE       = 4'd12;
    localparam logic [3:0] PH_ERROR      = 4'd15;

    localparam int N_ROUNDS_DEF = 10;

    localparam logic [7:0] DISP_ERROR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/phase_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT-1.
module phase_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/aes_phase_sequencer.sv
// Sequences one AES-128 run: start pulse, round tracking, result latch,
// byte stepping for the display, and stall detection.
module aes_phase_sequencer
    import aes_disp_pkg::*;
#(
    parameter int N_ROUNDS = N_ROUNDS_DEF,
    parameter int TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         set,
    input  logic         aes_round_tick,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         aes_start,
    output logic         busy,
    output logic [3:0]   cur_phase,
    output logic [7:0]   seven_num
);

    localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS);

    state_t       state, state_n;
    logic [3:0]   round, round_n;
    logic [3:0]   byte_idx, byte_idx_n;
    logic [127:0] result, result_n;
    logic [3:0]   phase_n;
    logic [7:0]   seven_n;
    logic [7:0]   round_disp;
    logic         wd_clear, wd_enable, wd_expired;

    assign wd_enable = (state == ST_LOAD) || (state == ST_ROUND);
    assign wd_clear  = (state_n != state) || aes_round_tick;

    phase_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_n    = state;
        round_n    = round;
        byte_idx_n = byte_idx;
        result_n   = result;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_n    = ST_LOAD;
                    round_n    = '0;
                    byte_idx_n = '0;
                end else if ((state == ST_DONE) && set) begin
                    byte_idx_n = byte_idx + 4'd1;
                end
            end
            ST_LOAD: begin
                if (aes_done || wd_expired) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_ROUND;
                    round_n = 4'd1;
                end
            end
            ST_ROUND: begin
                // done outranks a coincident tick, but only counts on the last round
                if (aes_done) begin
                    if (round == LAST_ROUND) begin
                        state_n  = ST_DONE;
                        result_n = aes_result;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else if (aes_round_tick) begin
                    if (round < LAST_ROUND) begin
                        round_n = round + 4'd1;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else if (wd_expired) begin
                    state_n = ST_ERROR;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they register alongside the state.
    always_comb begin
        phase_n    = PH_IDLE;
        seven_n    = '0;
        round_disp = (round_n >= 4'd10) ? {4'd1, round_n - 4'd10} : {4'd0, round_n};
        case (state_n)
            ST_IDLE:  begin phase_n = PH_IDLE;  seven_n = '0; end
            ST_LOAD:  begin phase_n = PH_LOAD;  seven_n = '0; end
            ST_ROUND: begin
                phase_n = PH_ROUND_BASE + round_n;
                seven_n = round_disp;
            end
            ST_DONE: begin
                phase_n = PH_DONE;
                // top bit of byte i sits at 127-8*i == {~i, 3'b111}
                seven_n = result_n[{~byte_idx_n, 3'b111} -: 8];
            end
            ST_ERROR: begin phase_n = PH_ERROR; seven_n = DISP_ERROR; end
            default:  begin phase_n = PH_IDLE;  seven_n = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            round     <= '0;
            byte_idx  <= '0;
            result    <= '0;
            cur_phase <= PH_IDLE;
            seven_num <= '0;
            busy      <= 1'b0;
            aes_start <= 1'b0;
        end else begin
            state     <= state_n;
            round     <= round_n;
            byte_idx  <= byte_idx_n;
            result    <= result_n;
            cur_phase <= phase_n;
            seven_num <= seven_n;
            busy      <= (state_n == ST_LOAD) || (state_n == ST_ROUND);
            aes_start <= (state_n == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_aes_phase_sequencer.sv
// Self-checking bench for aes_phase_sequencer: directed scenarios plus a
// randomized run, all compared against a phase-code level reference model.
module tb_aes_phase_sequencer;

    localparam int NR = 10;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0, start = 1'b0, set = 1'b0;
    logic         aes_round_tick = 1'b0, aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic         aes_start, busy;
    logic [3:0]   cur_phase;
    logic [7:0]   seven_num;

    int n_checks = 0;
    int n_errors = 0;
    string scen = "init";

    // reference model state: phase code, displayed byte index, result, stall count
    int           m_phase = 0;
    int           m_byte  = 0;
    int           m_wd    = 0;
    logic [127:0] m_result = '0;

    localparam logic [127:0] SEQ_RES = 128'h000102030405060708090A0B0C0D0E0F;

    always #20 clk = ~clk;

    aes_phase_sequencer #(
        .N_ROUNDS(NR),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .set           (set),
        .aes_round_tick(aes_round_tick),
        .aes_done      (aes_done),
        .aes_result    (aes_result),
        .aes_start     (aes_start),
        .busy          (busy),
        .cur_phase     (cur_phase),
        .seven_num     (seven_num)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return (m_phase >= 1) && (m_phase <= NR + 1);
    endfunction

    function automatic logic [7:0] m_seven();
        int k;
        if (m_phase == 12) return m_result[127 - 8*m_byte -: 8];
        if (m_phase == 15) return 8'hEE;
        if (m_phase >= 2 && m_phase <= NR + 1) begin
            k = m_phase - 1;
            return 8'((k / 10) * 16 + (k % 10));
        end
        return 8'h00;
    endfunction

    task automatic model_step(input logic r, st, se, tk, dn, input logic [127:0] res);
        int old;
        int k;
        if (r) begin
            m_phase = 0; m_byte = 0; m_wd = 0; m_result = '0;
            return;
        end
        old = m_phase;
        if (m_phase == 0 || m_phase == 12 || m_phase == 15) begin
            if (st) begin
                m_phase = 1; m_byte = 0; m_wd = 0;
            end else if (m_phase == 12 && se) begin
                m_byte = (m_byte + 1) % 16;
            end
        end else if (m_phase == 1) begin
            m_phase = (dn || m_wd == TO - 1) ? 15 : 2;
        end else begin
            k = m_phase - 1;
            if (dn) begin
                if (k == NR) begin m_result = res; m_phase = 12; end
                else m_phase = 15;
            end else if (tk) begin
                m_phase = (k < NR) ? m_phase + 1 : 15;
            end else if (m_wd == TO - 1) begin
                m_phase = 15;
            end
        end
        if (m_phase != old || tk) m_wd = 0;
        else if (m_busy()) m_wd++;
        else m_wd = 0;
    endtask

    task automatic step(input logic r, st, se, tk, dn, input logic [127:0] res);
        rst = r; start = st; set = se; aes_round_tick = tk; aes_done = dn; aes_result = res;
        @(posedge clk);
        model_step(r, st, se, tk, dn, res);
        #1;
        check({scen, ":cur_phase"}, 32'(cur_phase), 32'(m_phase));
        check({scen, ":busy"},      32'(busy),      32'(m_busy()));
        check({scen, ":aes_start"}, 32'(aes_start), 32'(m_phase == 1));
        check({scen, ":seven_num"}, 32'(seven_num), 32'(m_seven()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 0, '0);
            idle(1);
        end
    endtask

    task automatic run_to_done(input logic [127:0] res);
        step(0, 1, 0, 0, 0, '0);
        idle(1);
        ticks(NR - 1);
        step(0, 0, 0, 0, 1, res);
    endtask

    initial begin
        scen = "reset";
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        check("reset_phase", 32'(cur_phase), 32'd0);
        check("reset_seven", 32'(seven_num), 32'h00);

        scen = "start";
        step(0, 1, 0, 0, 0, '0);
        check("load_aes_start", 32'(aes_start), 32'd1);
        idle(1);
        check("r1_aes_start", 32'(aes_start), 32'd0);
        check("r1_phase", 32'(cur_phase), 32'd2);
        check("r1_seven", 32'(seven_num), 32'h01);

        scen = "rounds";
        ticks(NR - 1);
        check("r10_seven", 32'(seven_num), 32'h10);
        check("r10_phase", 32'(cur_phase), 32'd11);
        step(0, 0, 0, 0, 1, SEQ_RES);
        check("done_phase", 32'(cur_phase), 32'd12);
        check("done_byte0", 32'(seven_num), 32'h00);

        scen = "set";
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 0, 0, '0);
            check("set_byte", 32'(seven_num), 32'(i % 16));
        end

        scen = "early_done";
        step(0, 1, 0, 0, 0, '0);
        idle(1);
        ticks(3);
        step(0, 0, 0, 0, 1, {4{32'hDEADBEEF}});
        check("early_done_phase", 32'(cur_phase), 32'd15);
        check("early_done_seven", 32'(seven_num), 32'hEE);

        scen = "timeout";
        step(0, 1, 0, 0, 0, '0);
        idle(1);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        idle(TO - 1);
        check("wd_not_yet", 32'(cur_phase), 32'd4);
        idle(1);
        check("wd_error", 32'(cur_phase), 32'd15);
        step(0, 1, 0, 0, 0, '0);
        check("wd_recover", 32'(cur_phase), 32'd1);
        idle(1);

        scen = "start_set";
        ticks(NR - 1);
        step(0, 0, 0, 0, 1, SEQ_RES);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        step(0, 1, 1, 0, 0, '0);
        check("start_set_load", 32'(cur_phase), 32'd1);
        idle(1);
        ticks(NR - 1);
        step(0, 0, 0, 0, 1, 128'hA5000000_00000000_00000000_0000005A);
        check("start_set_byte0", 32'(seven_num), 32'hA5);

        scen = "start_busy";
        step(0, 1, 0, 0, 0, '0);
        idle(1);
        ticks(4);
        step(0, 1, 0, 0, 0, '0);
        check("start_ignored", 32'(cur_phase), 32'd6);

        scen = "rst_mid";
        ticks(2);
        check("r7_phase", 32'(cur_phase), 32'd8);
        step(1, 0, 0, 0, 0, '0);
        check("rst_phase", 32'(cur_phase), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);

        scen = "rand";
        for (int i = 0; i < 3000; i++) begin
            logic r, st, se, tk, dn;
            r  = ($urandom_range(0, 499) == 0);
            st = ($urandom_range(0, 29) == 0);
            se = ($urandom_range(0, 3) == 0);
            tk = ($urandom_range(0, 5) == 0);
            dn = (m_phase == NR + 1) ? ($urandom_range(0, 2) == 0)
                                     : ($urandom_range(0, 79) == 0);
            step(r, st, se, tk, dn, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_phase_sequencer.md
# aes_phase_sequencer

Sequences one AES-128 encryption run and produces the phase code and display byte consumed by the display controller (`cur_phase[3:0]`, `seven_num[7:0]`). It issues a start pulse to the AES core and tracks round-completion pulses. It latches the 128-bit result and lets the user step through the result bytes with `set`. A watchdog flags a stalled core.

## Interface
Parameters:
- `N_ROUNDS`, 10: rounds expected per encryption.
- `TIMEOUT`, 1024: maximum cycles allowed in any LOAD/ROUND phase without a core event.

Ports:
- `clk` in 1: 25 MHz clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: single-cycle pulse, already debounced; begins a run.
- `set` in 1: single-cycle pulse, already debounced; in DONE, advances the displayed byte.
- `aes_round_tick` in 1: pulse from the core, one per completed round.
- `aes_done` in 1: pulse from the core; `aes_result` is valid in the same cycle.
- `aes_result` in 128: ciphertext; byte 0 is `[127:120]`.
- `aes_start` out 1: one-cycle start pulse to the core.
- `busy` out 1: high in LOAD and ROUND phases.
- `cur_phase` out 4: phase code for the display controller.
- `seven_num` out 8: two-hex-digit display value.

## Operation
- Phase codes:
  - IDLE = 0
  - LOAD = 1
  - ROUND k = 1+k, for k = 1..10, giving 2..11
  - DONE = 12
  - ERROR = 15
- IDLE/DONE/ERROR + `start`:
  - Go to LOAD.
  - Clear the round counter, `byte_idx`, and the watchdog.
  - The result register is not cleared.
- LOAD:
  - Lasts exactly 1 cycle.
  - `aes_start` = 1 during it.
  - Next state is ROUND 1.
- ROUND k, `aes_round_tick` with k < N_ROUNDS: go to ROUND k+1.
- ROUND N_ROUNDS:
  - `aes_done` latches `aes_result` and goes to DONE.
  - `aes_round_tick` without `aes_done` goes to ERROR.
- `aes_round_tick` and `aes_done` in the same cycle: `aes_done` takes priority. The round count check still applies.
- `aes_done` in any ROUND k < N_ROUNDS, or in LOAD: go to ERROR, result not latched.
- Watchdog:
  - Counts cycles in LOAD/ROUND.
  - Cleared on every state change and on every `aes_round_tick`.
  - When it reaches TIMEOUT-1 with no event, go to ERROR on the next edge.
- DONE + `set`: `byte_idx` increments mod 16 (15 wraps to 0).
- `start` and `set` in the same cycle: `start` wins, `set` is ignored.
- `start` while `busy`: ignored.
- Core inputs in IDLE/DONE/ERROR: ignored.
- `seven_num` by phase:
  - IDLE: 8'h00.
  - LOAD: 8'h00.
  - ROUND k: k in packed BCD (round 10 shows 8'h10).
  - DONE: `result[127-8*byte_idx -: 8]`.
  - ERROR: 8'hEE.

## Timing
- All outputs are registered.
- Reset values: `cur_phase`=0, `seven_num`=8'h00, `aes_start`=0, `busy`=0; `byte_idx`=0 and result=0.
- `start` at edge n:
  - LOAD at n+1, with `aes_start`=1 and `busy`=1.
  - ROUND 1 (`cur_phase`=2) at n+2.
- An event sampled at edge n takes effect on `cur_phase`/`seven_num` at n+1 (1-cycle latency).
- DONE: `seven_num` shows byte 0 in the first DONE cycle. Each `set` changes it on the next edge.
- `rst` mid-run: IDLE at the next edge. `aes_start` is never re-asserted by reset.

## Structure
- Shared package `aes_disp_pkg`:
  - Phase code constants (IDLE, LOAD, ROUND_BASE=1, DONE, ERROR).
  - `N_ROUNDS` default.
  - ERROR display constant 8'hEE.
- One natural sub-module, `phase_watchdog`:
  - Inputs: `clear`, `enable`.
  - Output: `expired`.
  - Parameterised by TIMEOUT.
- BCD conversion of the round number and the result byte mux stay inline.

## Test plan
- Reset, then `start`: `aes_start` is high for exactly 1 cycle, then `cur_phase`=2 and `seven_num`=8'h01.
- 9 round ticks, then `aes_done` with `aes_result`=128'h000102…0F:
  - `cur_phase` steps 2→11, then 12.
  - `seven_num` shows 8'h10 in round 10, then 8'h00.
  - 16 `set` pulses show 8'h01…8'h0F, then wrap to 8'h00.
- `aes_done` during round 4: `cur_phase`=15, `seven_num`=8'hEE, result unchanged.
- No core events for TIMEOUT cycles in round 3: ERROR at cycle TIMEOUT. A subsequent `start` recovers to LOAD.
- Combined cases:
  - `start` and `set` together in DONE: a new run starts and `byte_idx`=0.
  - `start` during ROUND 5: ignored.
- `rst` asserted in ROUND 7: next cycle `cur_phase`=0, `seven_num`=8'h00, `busy`=0.
